// File: rtl/line_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// line_prefetch_pkg
// Shared constants, the fetch state encoding, and the SRAM address helper for
// the text-row prefetcher.
// No ports (package).
// -----------------------------------------------------------------------------
package line_prefetch_pkg;

  localparam int SRAM_ADDRESS_SIZE = 17;
  localparam int MEMORY_WORD_SIZE  = 16;
  localparam int WORDS_PER_ROW     = 20;
  localparam int ROW_STRIDE        = 40;
  localparam int WORD_STRIDE       = 2;

  localparam int ADDR_W = SRAM_ADDRESS_SIZE;
  localparam int DATA_W = MEMORY_WORD_SIZE;
  localparam int WORDS  = WORDS_PER_ROW;
  localparam int IDX_W  = $clog2(WORDS_PER_ROW);
  localparam int ROW_W  = 5;

  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS_PER_ROW - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_RELEASE
  } fetch_state_t;

  // base + row*ROW_STRIDE + word*WORD_STRIDE, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_address(
    input logic [ADDR_W-1:0] base,
    input logic [ROW_W-1:0]  row,
    input logic [IDX_W-1:0]  word
  );
    logic [ADDR_W-1:0] row_off;
    logic [ADDR_W-1:0] word_off;
    row_off  = ADDR_W'(row)  * ADDR_W'(ROW_STRIDE);
    word_off = ADDR_W'(word) * ADDR_W'(WORD_STRIDE);
    return base + row_off + word_off;
  endfunction

endpackage

// File: rtl/line_prefetch_if.sv
// -----------------------------------------------------------------------------
// line_prefetch_if
// Four-phase request bus between the prefetcher (master) and the
// memory_controller (slave).
//   mem_address          : request address (master -> slave)
//   mem_write_enable     : always 0 from this client (master -> slave)
//   mem_request          : four-phase request level (master -> slave)
//   mem_request_complete : completion level, slow domain (slave -> master)
//   mem_read_value       : read data, stable while complete is high
// -----------------------------------------------------------------------------
interface line_prefetch_if;
  import line_prefetch_pkg::*;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_enable;
  logic              mem_request;
  logic              mem_request_complete;
  logic [DATA_W-1:0] mem_read_value;

  modport master (
    output mem_address,
    output mem_write_enable,
    output mem_request,
    input  mem_request_complete,
    input  mem_read_value
  );

  modport slave (
    input  mem_address,
    input  mem_write_enable,
    input  mem_request,
    output mem_request_complete,
    output mem_read_value
  );

endinterface

// File: rtl/line_prefetch_bank_2x.sv
// -----------------------------------------------------------------------------
// line_prefetch_bank_2x
// Double-buffered line store: two WORDS x DATA_W register banks with one
// synchronous write port and one combinational read port.
//   clk      : system clock
//   wr_en    : write strobe
//   wr_bank  : bank selected for write
//   wr_index : word index for write (ignored when >= WORDS)
//   wr_data  : write data
//   rd_bank  : bank selected for read
//   rd_index : word index for read
//   rd_data  : read data, 0 when rd_index >= WORDS
// Contents are deliberately not reset.
// -----------------------------------------------------------------------------
module line_prefetch_bank_2x
  import line_prefetch_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] bank_rd [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [DATA_W-1:0] words [WORDS];

      always_ff @(posedge clk) begin
        if (wr_en && (wr_bank == 1'(gi)) && (wr_index <= LAST_WORD)) begin
          words[wr_index] <= wr_data;
        end
      end

      // The display may scan past the end of the row; those slots read as 0.
      assign bank_rd[gi] = (rd_index <= LAST_WORD) ? words[rd_index] : '0;
    end
  endgenerate

  assign rd_data = bank_rd[rd_bank];

endmodule

// File: rtl/line_prefetch.sv
// -----------------------------------------------------------------------------
// line_prefetch
// Fetches one text row (WORDS x 16-bit) from the SRAM over the four-phase
// memory_controller handshake into the back bank of a double-buffered store,
// while the pixel path reads the front bank combinationally.
//   clk, rst_n  : clock, synchronous active-low reset (effective when ena=1)
//   ena         : global enable; when low every flop holds
//   start       : row-boundary pulse: flip banks and fetch row_sel
//   row_sel     : row to fetch into the new back bank
//   base_addr   : SRAM address of row 0
//   mem         : request bus to memory_controller (master side)
//   rd_index    : display word index
//   rd_data     : word from the front bank (0 past the row end)
//   front_bank  : bank currently displayed
//   busy        : a fetch is in progress
//   overrun     : sticky, start seen while busy
// -----------------------------------------------------------------------------
module line_prefetch
  import line_prefetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [ROW_W-1:0]  row_sel,
  input  logic [ADDR_W-1:0] base_addr,
  line_prefetch_if.master   mem,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [DATA_W-1:0] rd_data,
  output logic              front_bank,
  output logic              busy,
  output logic              overrun
);

  fetch_state_t      state_reg, state_next;
  logic              cmp_meta_reg, cmp_s_reg;
  logic [ROW_W-1:0]  row_q_reg, row_q_next;
  logic [ROW_W-1:0]  pend_row_reg, pend_row_next;
  logic              pending_reg, pending_next;
  logic [IDX_W-1:0]  word_ptr_reg, word_ptr_next;
  logic              front_reg, front_next;
  logic              tgt_bank_reg, tgt_bank_next;
  logic              busy_reg, busy_next;
  logic              overrun_reg, overrun_next;
  logic              req_reg, req_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              last_word;
  logic              restart;
  logic              bank_we;

  assign last_word = (word_ptr_reg == LAST_WORD);
  // A start arriving in the very cycle RELEASE exits counts as a restart,
  // so it beats the end-of-row exit and busy stays high.
  assign restart   = pending_reg | start;

  // Completion comes from the slow divided-clock domain.
  always_ff @(posedge clk) begin
    if (ena) begin
      if (!rst_n) begin
        cmp_meta_reg <= 1'b0;
        cmp_s_reg    <= 1'b0;
      end else begin
        cmp_meta_reg <= mem.mem_request_complete;
        cmp_s_reg    <= cmp_meta_reg;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (ena) begin
      if (!rst_n) begin
        state_reg <= ST_IDLE;
      end else begin
        state_reg <= state_next;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (start)      state_next = ST_ISSUE;
      ST_ISSUE:    if (!cmp_s_reg) state_next = ST_WAIT_ACK;
      ST_WAIT_ACK: if (cmp_s_reg)  state_next = ST_RELEASE;
      ST_RELEASE: begin
        if (!cmp_s_reg) begin
          state_next = (restart || !last_word) ? ST_ISSUE : ST_IDLE;
        end
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    row_q_next    = row_q_reg;
    pend_row_next = pend_row_reg;
    pending_next  = pending_reg;
    word_ptr_next = word_ptr_reg;
    front_next    = front_reg;
    tgt_bank_next = tgt_bank_reg;
    overrun_next  = overrun_reg;
    addr_next     = addr_reg;

    // Request is high exactly while waiting for the acknowledge; registered
    // so the slow domain never sees decode glitches.
    req_next  = (state_next == ST_WAIT_ACK);
    busy_next = (state_next != ST_IDLE);
    bank_we   = ena && rst_n && (state_reg == ST_WAIT_ACK) && cmp_s_reg;

    if (start) begin
      front_next = ~front_reg;
      if (state_reg == ST_IDLE) begin
        row_q_next    = row_sel;
        word_ptr_next = '0;
      end else begin
        overrun_next  = 1'b1;
        pend_row_next = row_sel;
        pending_next  = 1'b1;
      end
    end

    // The in-flight word lands in whichever bank was back when it was issued,
    // even if the banks flip before it completes.
    if ((state_reg == ST_ISSUE) && !cmp_s_reg) begin
      tgt_bank_next = ~front_reg;
    end

    if ((state_reg == ST_RELEASE) && !cmp_s_reg) begin
      if (restart) begin
        word_ptr_next = '0;
        row_q_next    = start ? row_sel : pend_row_reg;
        pending_next  = 1'b0;
      end else if (!last_word) begin
        word_ptr_next = word_ptr_reg + 1'b1;
      end
    end

    // Address settles on ISSUE entry, a cycle ahead of the request edge.
    if (state_next == ST_ISSUE) begin
      addr_next = word_address(base_addr, row_q_next, word_ptr_next);
    end
  end

  always_ff @(posedge clk) begin
    if (ena) begin
      if (!rst_n) begin
        row_q_reg    <= '0;
        pend_row_reg <= '0;
        pending_reg  <= 1'b0;
        word_ptr_reg <= '0;
        front_reg    <= 1'b0;
        tgt_bank_reg <= 1'b0;
        busy_reg     <= 1'b0;
        overrun_reg  <= 1'b0;
        req_reg      <= 1'b0;
        addr_reg     <= '0;
      end else begin
        row_q_reg    <= row_q_next;
        pend_row_reg <= pend_row_next;
        pending_reg  <= pending_next;
        word_ptr_reg <= word_ptr_next;
        front_reg    <= front_next;
        tgt_bank_reg <= tgt_bank_next;
        busy_reg     <= busy_next;
        overrun_reg  <= overrun_next;
        req_reg      <= req_next;
        addr_reg     <= addr_next;
      end
    end
  end

  line_prefetch_bank_2x u_bank (
    .clk      (clk),
    .wr_en    (bank_we),
    .wr_bank  (tgt_bank_reg),
    .wr_index (word_ptr_reg),
    .wr_data  (mem.mem_read_value),
    .rd_bank  (front_reg),
    .rd_index (rd_index),
    .rd_data  (rd_data)
  );

  assign mem.mem_address      = addr_reg;
  assign mem.mem_request      = req_reg;
  assign mem.mem_write_enable = 1'b0;
  assign front_bank           = front_reg;
  assign busy                 = busy_reg;
  assign overrun              = overrun_reg;

endmodule

// File: tb/tb_line_prefetch.sv
module tb_line_prefetch;
  import line_prefetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ena;
  logic        start;
  logic [4:0]  row_sel;
  logic [16:0] base_addr;
  logic [4:0]  rd_index;
  logic [15:0] rd_data;
  logic        front_bank;
  logic        busy;
  logic        overrun;

  line_prefetch_if mem_if ();

  line_prefetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .row_sel    (row_sel),
    .base_addr  (base_addr),
    .mem        (mem_if),
    .rd_index   (rd_index),
    .rd_data    (rd_data),
    .front_bank (front_bank),
    .busy       (busy),
    .overrun    (overrun)
  );

  int          checks = 0;
  int          failures = 0;
  logic [16:0] exp_q [$];
  int          rise_count = 0;
  int          hold_extra = 0;
  logic [15:0] prev_row [20];
  logic        prev_valid = 1'b0;
  logic        exp_front = 1'b0;
  logic        req_prev = 1'b0;
  logic        got_cmp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: row r word w lives at (base + 40*r + 2*w) mod 2^17.
  function automatic logic [16:0] ref_addr(input int base, input int row, input int w);
    int a;
    a = (base + row * 40 + w * 2) % 131072;
    return 17'(a);
  endfunction

  function automatic logic [15:0] ref_data(input int base, input int row, input int w);
    logic [16:0] a;
    a = ref_addr(base, row, w);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // Memory controller model on a /4 slow clock.
  initial begin : mem_model
    int div;
    int mst;
    int cnt;
    int hold;
    logic [16:0] a;
    div = 0; mst = 0; cnt = 0; hold = 0;
    mem_if.mem_request_complete = 1'b0;
    mem_if.mem_read_value = '0;
    forever begin
      @(negedge clk);
      div++;
      if (div % 4 == 0) begin
        case (mst)
          0: begin
            if (mem_if.mem_request === 1'b1) begin
              cnt = int'($urandom_range(0, 3));
              mst = 1;
            end
          end
          1: begin
            if (mem_if.mem_request !== 1'b1) begin
              mst = 0;
            end else if (cnt == 0) begin
              a = mem_if.mem_address;
              mem_if.mem_read_value = a[15:0] ^ 16'hA5A5;
              mem_if.mem_request_complete = 1'b1;
              hold = hold_extra;
              mst = 2;
            end else begin
              cnt--;
            end
          end
          2: begin
            if (mem_if.mem_request !== 1'b1) begin
              if (hold == 0) begin
                mem_if.mem_request_complete = 1'b0;
                mst = 0;
              end else begin
                hold--;
              end
            end
          end
          default: mst = 0;
        endcase
      end
    end
  end

  // Scoreboard monitor: every request rising edge pops one expected address.
  initial begin : monitor
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if ((mem_if.mem_request === 1'b1) && !req_prev) begin
        rise_count++;
        check("req_rise_while_complete", 32'(mem_if.mem_request_complete), 32'(0));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_request actual=%0h required=none", mem_if.mem_address);
        end else begin
          e = exp_q.pop_front();
          check("req_addr", 32'(mem_if.mem_address), 32'(e));
        end
      end
      if ((mem_if.mem_request !== 1'b1) && req_prev) begin
        if (rst_n) check("req_held_until_complete", 32'(got_cmp), 32'(1));
        got_cmp = 1'b0;
      end
      if ((mem_if.mem_request === 1'b1) && (mem_if.mem_request_complete === 1'b1)) got_cmp = 1'b1;
      req_prev = (mem_if.mem_request === 1'b1);
    end
  end

  task automatic push_row(input int base, input int row, input int n);
    for (int w = 0; w < n; w++) exp_q.push_back(ref_addr(base, row, w));
  endtask

  task automatic save_row(input int base, input int row);
    for (int w = 0; w < 20; w++) prev_row[w] = ref_data(base, row, w);
    prev_valid = 1'b1;
  endtask

  task automatic do_start(input int row, input int base);
    @(negedge clk);
    row_sel = 5'(row);
    base_addr = 17'(base);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_front = ~exp_front;
    check("front_bank_toggle", 32'(front_bank), 32'(exp_front));
  endtask

  task automatic check_prev();
    int i;
    if (prev_valid) begin
      for (int k = 0; k < 5; k++) begin
        i = int'($urandom_range(0, 19));
        rd_index = 5'(i);
        #1;
        check("rd_data_front", 32'(rd_data), 32'(prev_row[i]));
      end
    end
  endtask

  task automatic wait_done(input int r0, input int nexp);
    int t;
    t = 0;
    while (busy === 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=busy required=idle");
    end
    check("busy_low", 32'(busy), 32'(0));
    check("request_edges", 32'(rise_count - r0), 32'(nexp));
    check("queue_drained", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_rises(input int r0, input int n);
    int t;
    t = 0;
    while ((rise_count - r0) < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) begin
      checks++;
      failures++;
      $display("FAIL rise_timeout actual=%0d required=%0d", rise_count - r0, n);
    end
  endtask

  task automatic run_row(input int row, input int base);
    int r0;
    push_row(base, row, 20);
    r0 = rise_count;
    do_start(row, base);
    check("busy_after_start", 32'(busy), 32'(1));
    check_prev();
    wait_done(r0, 20);
    save_row(base, row);
    $display("row=%0d base=%05h fetched front_bank=%0d", row, base, front_bank);
  endtask

  initial begin : stim
    int r0;
    int ra, rb, ba, bb;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0;
    row_sel = '0; base_addr = '0; rd_index = '0;
    repeat (3) @(negedge clk);
    check("reset_req", 32'(mem_if.mem_request), 32'(0));
    check("reset_addr", 32'(mem_if.mem_address), 32'(0));
    check("reset_we", 32'(mem_if.mem_write_enable), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_front", 32'(front_bank), 32'(0));
    check("reset_overrun", 32'(overrun), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Row 0 at base 0.
    run_row(0, 0);

    // Wrapping row; previous row becomes visible only now.
    push_row(17'h1FFF0, 29, 20);
    r0 = rise_count;
    do_start(29, 17'h1FFF0);
    check("first_addr_wrap_ref", 32'(exp_q[0]), 32'(17'h00478));
    rd_index = 5'd3;
    #1;
    check("rd_data_idx3", 32'(rd_data), 32'(16'hA5A3));
    rd_index = 5'd25;
    #1;
    check("rd_data_past_end", 32'(rd_data), 32'(0));
    check_prev();
    wait_done(r0, 20);
    save_row(17'h1FFF0, 29);
    $display("row=29 base=1fff0 fetched (wrap)");

    // Random rows; the middle one with completion held 10 slow clocks longer.
    for (int k = 0; k < 3; k++) begin
      hold_extra = (k == 1) ? 10 : 0;
      run_row(int'($urandom_range(0, 31)), int'($urandom_range(0, 131071)));
    end
    hold_extra = 0;

    // Overrun: start again while word 7 is waiting for its acknowledge.
    ra = int'($urandom_range(0, 31)); ba = int'($urandom_range(0, 131071));
    rb = int'($urandom_range(0, 31)); bb = int'($urandom_range(0, 131071));
    push_row(ba, ra, 8);
    r0 = rise_count;
    do_start(ra, ba);
    check_prev();
    wait_rises(r0, 8);
    push_row(bb, rb, 20);
    do_start(rb, bb);
    check("overrun_set", 32'(overrun), 32'(1));
    check("inflight_req_held", 32'(mem_if.mem_request), 32'(1));
    check("busy_during_overrun", 32'(busy), 32'(1));
    wait_done(r0, 28);
    save_row(bb, rb);
    $display("overrun row=%0d restarted as row=%0d overrun=%0d", ra, rb, overrun);

    // Freeze with ena=0 while word 4 is requested.
    ra = int'($urandom_range(0, 31)); ba = int'($urandom_range(0, 131071));
    push_row(ba, ra, 20);
    r0 = rise_count;
    do_start(ra, ba);
    check_prev();
    wait_rises(r0, 5);
    ena = 1'b0;
    repeat (100) @(negedge clk);
    check("freeze_req", 32'(mem_if.mem_request), 32'(1));
    check("freeze_addr", 32'(mem_if.mem_address), 32'(ref_addr(ba, ra, 4)));
    check("freeze_busy", 32'(busy), 32'(1));
    ena = 1'b1;
    wait_done(r0, 20);
    save_row(ba, ra);
    $display("row=%0d fetched across 100-cycle freeze", ra);

    // Reset while waiting for an acknowledge.
    ra = int'($urandom_range(0, 31)); ba = int'($urandom_range(0, 131071));
    push_row(ba, ra, 20);
    r0 = rise_count;
    do_start(ra, ba);
    check_prev();
    wait_rises(r0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_req", 32'(mem_if.mem_request), 32'(0));
    check("midreset_busy", 32'(busy), 32'(0));
    check("midreset_overrun", 32'(overrun), 32'(0));
    check("midreset_front", 32'(front_bank), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_front = 1'b0;
    exp_q.delete();
    prev_valid = 1'b0;
    repeat (60) @(negedge clk);
    $display("reset during WAIT_ACK recovered");

    run_row(int'($urandom_range(0, 31)), int'($urandom_range(0, 131071)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
